// File: rtl/vr_log_pkg.sv
// Shared VR replica log definitions: geometry, header layout and writer/reader states.
package vr_log_pkg;

  localparam int DATA_W      = 512;
  localparam int HDR_IDX_W   = 8;
  localparam int DATA_ADDR_W = 12;
  localparam int BYTES_W     = 16;
  localparam int BPL         = DATA_W / 8;
  localparam int BPL_SHIFT   = $clog2(BPL);

  typedef struct packed {
    logic [31:0]            view;
    logic [63:0]            op_num;
    logic [DATA_ADDR_W-1:0] data_start_addr;
    logic [BYTES_W-1:0]     bytes;
  } log_hdr_struct;

  localparam int LOG_HDR_W = $bits(log_hdr_struct);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    WR_DATA = 2'd1,
    WR_HDR  = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Payload lines needed for a byte count; one extra bit so the rounding add cannot overflow.
  function automatic logic [BYTES_W:0] line_count(input logic [BYTES_W-1:0] bytes);
    logic [BYTES_W:0] padded;
    padded = {1'b0, bytes} + (BYTES_W+1)'(BPL - 1);
    return padded >> BPL_SHIFT;
  endfunction

endpackage

// File: rtl/log_writer_ctrl_if.sv
// Bundle of every handshake and status signal around the log writer.
// master = the environment (sources, memories, done sink); slave = the writer itself.
interface log_writer_ctrl_if;
  import vr_log_pkg::*;

  logic                   src_writer_req_val;
  logic                   src_writer_req_rdy;
  logic [31:0]            src_writer_req_view;
  logic [63:0]            src_writer_req_op_num;
  logic [BYTES_W-1:0]     src_writer_req_bytes;

  logic                   src_writer_data_val;
  logic                   src_writer_data_rdy;
  logic [DATA_W-1:0]      src_writer_data;
  logic                   src_writer_data_last;

  logic                   writer_log_data_mem_wr_req_val;
  logic                   log_data_mem_writer_wr_req_rdy;
  logic [DATA_ADDR_W-1:0] writer_log_data_mem_wr_req_addr;
  logic [DATA_W-1:0]      writer_log_data_mem_wr_req_data;

  logic                   writer_log_hdr_mem_wr_req_val;
  logic                   log_hdr_mem_writer_wr_req_rdy;
  logic [HDR_IDX_W-1:0]   writer_log_hdr_mem_wr_req_addr;
  log_hdr_struct          writer_log_hdr_mem_wr_req_data;

  logic                   writer_dst_done_val;
  logic                   writer_dst_done_rdy;
  logic [63:0]            writer_dst_done_op_num;

  logic [DATA_ADDR_W-1:0] data_wr_ptr;
  logic                   len_err;

  modport master (
    output src_writer_req_val, src_writer_req_view, src_writer_req_op_num, src_writer_req_bytes,
    input  src_writer_req_rdy,
    output src_writer_data_val, src_writer_data, src_writer_data_last,
    input  src_writer_data_rdy,
    input  writer_log_data_mem_wr_req_val, writer_log_data_mem_wr_req_addr,
    input  writer_log_data_mem_wr_req_data,
    output log_data_mem_writer_wr_req_rdy,
    input  writer_log_hdr_mem_wr_req_val, writer_log_hdr_mem_wr_req_addr,
    input  writer_log_hdr_mem_wr_req_data,
    output log_hdr_mem_writer_wr_req_rdy,
    input  writer_dst_done_val, writer_dst_done_op_num,
    output writer_dst_done_rdy,
    input  data_wr_ptr, len_err
  );

  modport slave (
    input  src_writer_req_val, src_writer_req_view, src_writer_req_op_num, src_writer_req_bytes,
    output src_writer_req_rdy,
    input  src_writer_data_val, src_writer_data, src_writer_data_last,
    output src_writer_data_rdy,
    output writer_log_data_mem_wr_req_val, writer_log_data_mem_wr_req_addr,
    output writer_log_data_mem_wr_req_data,
    input  log_data_mem_writer_wr_req_rdy,
    output writer_log_hdr_mem_wr_req_val, writer_log_hdr_mem_wr_req_addr,
    output writer_log_hdr_mem_wr_req_data,
    input  log_hdr_mem_writer_wr_req_rdy,
    output writer_dst_done_val, writer_dst_done_op_num,
    input  writer_dst_done_rdy,
    output data_wr_ptr, len_err
  );

endinterface

// File: rtl/log_writer_ctrl_fsm.sv
// Entry sequencing for the log writer: READY -> (WR_DATA) -> WR_HDR -> DONE.
// All handshake strobes are registered so they change only on state transitions.
module log_writer_ctrl_fsm
  import vr_log_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_fire,
  input  logic req_empty,
  input  logic data_fire,
  input  logic last_line,
  input  logic hdr_fire,
  input  logic done_fire,
  output logic req_rdy,
  output logic data_phase,
  output logic hdr_val,
  output logic done_val
);

  state_e state_reg;

  // State and strobes advance together; the header is only raised after the final line fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= READY;
      req_rdy    <= 1'b1;
      data_phase <= 1'b0;
      hdr_val    <= 1'b0;
      done_val   <= 1'b0;
    end else begin
      case (state_reg)
        READY: begin
          if (req_fire) begin
            req_rdy <= 1'b0;
            if (req_empty) begin
              state_reg <= WR_HDR;
              hdr_val   <= 1'b1;
            end else begin
              state_reg  <= WR_DATA;
              data_phase <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (data_fire && last_line) begin
            state_reg  <= WR_HDR;
            data_phase <= 1'b0;
            hdr_val    <= 1'b1;
          end
        end
        WR_HDR: begin
          if (hdr_fire) begin
            state_reg <= DONE;
            hdr_val   <= 1'b0;
            done_val  <= 1'b1;
          end
        end
        DONE: begin
          if (done_fire) begin
            state_reg <= READY;
            done_val  <= 1'b0;
            req_rdy   <= 1'b1;
          end
        end
        default: begin
          state_reg  <= READY;
          req_rdy    <= 1'b1;
          data_phase <= 1'b0;
          hdr_val    <= 1'b0;
          done_val   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/log_writer_ctrl.sv
// Log writer top: entry latches, circular data pointer and line counter around the FSM.
// Payload lines pass straight through to the data memory while the FSM is in WR_DATA.
module log_writer_ctrl
  import vr_log_pkg::*;
(
  input logic              clk,
  input logic              rst,
  log_writer_ctrl_if.slave bus
);

  logic                   req_rdy;
  logic                   data_phase;
  logic                   hdr_val;
  logic                   done_val;
  logic                   req_fire;
  logic                   data_fire;
  logic                   hdr_fire;
  logic                   done_fire;
  logic                   last_line;

  logic [31:0]            view_reg;
  logic [63:0]            op_num_reg;
  logic [BYTES_W-1:0]     bytes_reg;
  logic [DATA_ADDR_W-1:0] start_reg;
  logic [DATA_ADDR_W-1:0] ptr_reg;
  logic [BYTES_W:0]       lines_left_reg;
  logic                   len_err_reg;
  log_hdr_struct          hdr_word;

  assign req_fire  = bus.src_writer_req_val & req_rdy;
  assign data_fire = data_phase & bus.src_writer_data_val & bus.log_data_mem_writer_wr_req_rdy;
  assign hdr_fire  = hdr_val & bus.log_hdr_mem_writer_wr_req_rdy;
  assign done_fire = done_val & bus.writer_dst_done_rdy;
  assign last_line = (lines_left_reg == (BYTES_W+1)'(1));

  log_writer_ctrl_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .req_fire   (req_fire),
    .req_empty  (bus.src_writer_req_bytes == '0),
    .data_fire  (data_fire),
    .last_line  (last_line),
    .hdr_fire   (hdr_fire),
    .done_fire  (done_fire),
    .req_rdy    (req_rdy),
    .data_phase (data_phase),
    .hdr_val    (hdr_val),
    .done_val   (done_val)
  );

  // Latch entry metadata on accept; advance pointer and count lines on every payload write.
  always_ff @(posedge clk) begin
    if (rst) begin
      view_reg       <= '0;
      op_num_reg     <= '0;
      bytes_reg      <= '0;
      start_reg      <= '0;
      ptr_reg        <= '0;
      lines_left_reg <= '0;
      len_err_reg    <= 1'b0;
    end else begin
      if (req_fire) begin
        view_reg       <= bus.src_writer_req_view;
        op_num_reg     <= bus.src_writer_req_op_num;
        bytes_reg      <= bus.src_writer_req_bytes;
        start_reg      <= ptr_reg;
        lines_left_reg <= line_count(bus.src_writer_req_bytes);
      end
      if (data_fire) begin
        ptr_reg        <= ptr_reg + DATA_ADDR_W'(1);
        lines_left_reg <= lines_left_reg - (BYTES_W+1)'(1);
        // last must coincide exactly with the final counted line; the count still wins.
        if (bus.src_writer_data_last != last_line)
          len_err_reg <= 1'b1;
      end
    end
  end

  // Header word assembled from the latched entry.
  always_comb begin
    hdr_word                 = '0;
    hdr_word.view            = view_reg;
    hdr_word.op_num          = op_num_reg;
    hdr_word.data_start_addr = start_reg;
    hdr_word.bytes           = bytes_reg;
  end

  assign bus.src_writer_req_rdy              = req_rdy;
  assign bus.src_writer_data_rdy             = data_phase & bus.log_data_mem_writer_wr_req_rdy;
  assign bus.writer_log_data_mem_wr_req_val  = data_phase & bus.src_writer_data_val;
  assign bus.writer_log_data_mem_wr_req_addr = ptr_reg;
  assign bus.writer_log_data_mem_wr_req_data = bus.src_writer_data;
  assign bus.writer_log_hdr_mem_wr_req_val   = hdr_val;
  assign bus.writer_log_hdr_mem_wr_req_addr  = op_num_reg[HDR_IDX_W-1:0];
  assign bus.writer_log_hdr_mem_wr_req_data  = hdr_word;
  assign bus.writer_dst_done_val             = done_val;
  assign bus.writer_dst_done_op_num          = op_num_reg;
  assign bus.data_wr_ptr                     = ptr_reg;
  assign bus.len_err                         = len_err_reg;

endmodule
